// File: rtl/alarm_pkg.sv
// Shared definitions for the home-alarm control path.
//   - State encodings (IDLE..ALARM), fixed at 3 bits.
//   - Default sizing and delay constants used as parameter defaults.
package alarm_pkg;

   localparam int unsigned STATE_W     = 3;
   localparam int unsigned NZ_DEF      = 4;
   localparam int unsigned CNT_W_DEF   = 8;
   localparam int unsigned EXIT_S_DEF  = 30;
   localparam int unsigned ENTRY_S_DEF = 20;
   localparam int unsigned SIREN_S_DEF = 180;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      EXIT  = 3'd1,
      ARMED = 3'd2,
      ENTRY = 3'd3,
      ALARM = 3'd4
   } alarmState_t;

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter shared by all timed alarm phases.
// Ports:
//   clkSignal, RST  clock, asynchronous active-high reset
//   load, loadVal   reload the count (load wins over a coincident tick)
//   tick            1 Hz one-cycle pulse; decrements while count > 0
//   count           current count
//   expire_c        combinational: tick while count is 1 (or 0, so a
//                   zero-length phase ends on its first tick)
module sec_countdown #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clkSignal,
   input  logic             RST,
   input  logic             load,
   input  logic [CNT_W-1:0] loadVal,
   input  logic             tick,
   output logic [CNT_W-1:0] count,
   output logic             expire_c
);

   assign expire_c = tick && (count <= CNT_W'(1));

   // Count register: load has priority, then saturating decrement on tick.
   always_ff @(posedge clkSignal or posedge RST) begin
      if (RST) begin
         count <= '0;
      end else if (load) begin
         count <= loadVal;
      end else if (tick && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// Main control FSM for the home alarm: IDLE -> EXIT -> ARMED -> ENTRY -> ALARM.
// Ports:
//   clkSignal, RST   clock, asynchronous active-high reset
//   tick             1 Hz pulse from the prescaler
//   arm, disarm      one-cycle keypad pulses
//   zone             tripped sensor zones (synchronised upstream)
//   instant_mask     zones that skip the entry delay
//   siren            siren drive (registered, from next state)
//   armed_led        high in EXIT/ARMED/ENTRY/ALARM (registered, from next state)
//   beep             one-cycle pulse after each tick seen in EXIT/ENTRY
//   state            current state encoding
//   remaining        seconds left in the current timed phase, 0 when untimed
//   trip_zone        zones that caused the last ENTRY/ALARM
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int unsigned NZ      = NZ_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned EXIT_S  = EXIT_S_DEF,
   parameter int unsigned ENTRY_S = ENTRY_S_DEF,
   parameter int unsigned SIREN_S = SIREN_S_DEF
) (
   input  logic               clkSignal,
   input  logic               RST,
   input  logic               tick,
   input  logic               arm,
   input  logic               disarm,
   input  logic [NZ-1:0]      zone,
   input  logic [NZ-1:0]      instant_mask,
   output logic               siren,
   output logic               armed_led,
   output logic               beep,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   remaining,
   output logic [NZ-1:0]      trip_zone
);

   localparam longint unsigned MaxDelay = (longint'(1) << CNT_W) - 1;

   // Refuse to elaborate with a delay the countdown cannot hold.
   if ((longint'(EXIT_S) > MaxDelay) || (longint'(ENTRY_S) > MaxDelay) ||
       (longint'(SIREN_S) > MaxDelay)) begin : gBadDelay
      $error("alarm_sequencer: delay parameter exceeds 2^CNT_W-1");
   end

   alarmState_t      stateQ;
   alarmState_t      nextState;
   logic             instHit;
   logic             anyZone;
   logic             expire;
   logic             load;
   logic [CNT_W-1:0] loadVal;

   assign instHit = |(zone & instant_mask);
   assign anyZone = |zone;
   assign state   = stateQ;

   // Next-state decode; order inside each state encodes event priority.
   always_comb begin
      nextState = stateQ;
      case (stateQ)
         IDLE:  if (arm) nextState = EXIT;
         EXIT: begin
            if (disarm)      nextState = IDLE;
            else if (expire) nextState = ARMED;
         end
         ARMED: begin
            if (disarm)       nextState = IDLE;
            else if (instHit) nextState = ALARM;
            else if (anyZone) nextState = ENTRY;
         end
         ENTRY: begin
            if (disarm)       nextState = IDLE;
            else if (instHit) nextState = ALARM;
            else if (expire)  nextState = ALARM;
         end
         ALARM: begin
            if (disarm)      nextState = IDLE;
            else if (expire) nextState = ARMED;
         end
         default: nextState = IDLE;
      endcase
   end

   // Every state change reloads the countdown; untimed states load 0.
   always_comb begin
      load    = (nextState != stateQ);
      loadVal = '0;
      case (nextState)
         EXIT:    loadVal = CNT_W'(EXIT_S);
         ENTRY:   loadVal = CNT_W'(ENTRY_S);
         ALARM:   loadVal = CNT_W'(SIREN_S);
         default: loadVal = '0;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clkSignal or posedge RST) begin
      if (RST) begin
         stateQ    <= IDLE;
         siren     <= 1'b0;
         armed_led <= 1'b0;
         beep      <= 1'b0;
         trip_zone <= '0;
      end else begin
         stateQ    <= nextState;
         siren     <= (nextState == ALARM);
         armed_led <= (nextState != IDLE);
         beep      <= tick && ((stateQ == EXIT) || (stateQ == ENTRY));
         if ((stateQ == IDLE) && (nextState == EXIT)) begin
            trip_zone <= '0;
         end else if ((stateQ == ARMED) &&
                      ((nextState == ENTRY) || (nextState == ALARM))) begin
            trip_zone <= zone;
         end else if ((stateQ == ENTRY) && (nextState != IDLE)) begin
            trip_zone <= trip_zone | zone;
         end
      end
   end

   sec_countdown #(
      .CNT_W (CNT_W)
   ) uCountdown (
      .clkSignal (clkSignal),
      .RST       (RST),
      .load      (load),
      .loadVal   (loadVal),
      .tick      (tick),
      .count     (remaining),
      .expire_c  (expire)
   );

endmodule
